usb_audio_playout_ctrl: RTL and testbench

//  Playback scheduler between the USB full-speed core OUT byte stream and the audio DAC.
//  - Packs 4-byte stereo PCM frames (L lsb, L msb, R lsb, R msb) into a circular frame FIFO.
//  - Releases one frame per 48 kHz sample tick after a prefill.
//  - Trims the tick period by +/-1 clk from FIFO level to absorb host/device clock drift.
//  - Mutes and refills on underrun; drops frames on overflow.

---
 rtl/usb_audio_playout_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_usb_audio_playout_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_audio_playout_ctrl.sv
// USB audio playout scheduler: packs OUT-endpoint bytes into stereo frames,
// buffers them in a circular frame FIFO and releases one frame per sample
// tick. The tick period is trimmed by one clock from the FIFO level so the
// buffer tracks host/device clock drift. Underrun mutes and re-enters prefill;
// frames arriving into a full FIFO are dropped and counted.
module usb_audio_playout_ctrl #(
  parameter int unsigned CLK_DIV      = 1250,
  parameter int unsigned DEPTH_LOG2   = 8,
  parameter int unsigned PREFILL      = 96,
  parameter int unsigned HIGH_WM      = 192,
  parameter int unsigned LOW_WM       = 48,
  parameter int unsigned GAP_CYCLES   = 600,
  parameter bit          UNSIGNED_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            out_data,
  input  logic                  out_valid,
  output logic [15:0]           audio_lch,
  output logic [15:0]           audio_rch,
  output logic                  sample_stb,
  output logic                  playing,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            underrun_cnt,
  output logic [7:0]            overflow_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int          LW    = DEPTH_LOG2 + 1;
  localparam int          CW    = $clog2(CLK_DIV + 2);
  localparam int          IW    = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] PER_NOM  = CW'(CLK_DIV);
  localparam logic [CW-1:0] PER_FAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] PER_SLOW = CW'(CLK_DIV + 1);
  localparam logic [IW-1:0] GAP_LIM  = IW'(GAP_CYCLES);
  localparam logic [LW-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [15:0]   MUTE     = UNSIGNED_OUT ? 16'h8000 : 16'h0000;

  typedef enum logic {
    S_FILL = 1'b0,
    S_PLAY = 1'b1
  } state_t;

  // Counter increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Assemble a DAC sample from its two bytes, optionally to offset binary.
  function automatic logic [15:0] fmt_sample(input logic [7:0] lsb, input logic [7:0] msb);
    return {msb[7] ^ UNSIGNED_OUT, msb[6:0], lsb};
  endfunction

  state_t          state;
  logic [1:0]      phase;
  logic [IW-1:0]   idle_cnt;
  logic [7:0]      byte0;
  logic [7:0]      byte1;
  logic [7:0]      byte2;
  logic [31:0]     mem [DEPTH];
  logic [LW-1:0]   wr_ptr;
  logic [LW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [31:0]     level_w;
  logic [31:0]     rd_frame;
  logic            full;
  logic            push_req;
  logic            push_ok;
  logic            push_drop;
  logic [CW-1:0]   tick_cnt;
  logic [CW-1:0]   period;
  logic [CW-1:0]   next_period;
  logic            tick;
  logic            prefill_ok;
  logic            pop;

  // Level arithmetic relies on the extra pointer bit to tell full from empty.
  assign level      = wr_ptr - rd_ptr;
  assign level_w    = 32'(level);
  assign fifo_level = level;
  assign full       = (level == FULL_LVL);

  // A frame is complete on the fourth byte; a full FIFO drops it.
  assign push_req   = out_valid && (phase == 2'd3);
  assign push_ok    = push_req && !full;
  assign push_drop  = push_req && full;

  assign rd_frame   = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign tick       = (tick_cnt == period - CW'(1));
  assign prefill_ok = (level_w >= PREFILL);

  // A FILL tick with enough buffered data pops immediately, as does any PLAY tick with data.
  assign pop = tick && (((state == S_FILL) && prefill_ok) ||
                        ((state == S_PLAY) && (level != '0)));

  // Drift trim: a full buffer shortens the period, a starving one lengthens it.
  always_comb begin
    next_period = PER_NOM;
    if (level_w > HIGH_WM) begin
      next_period = PER_FAST;
    end else if (level_w < LOW_WM) begin
      next_period = PER_SLOW;
    end
  end

  // Byte phase tracking; a long idle gap realigns to a frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase    <= 2'd0;
      idle_cnt <= '0;
    end else if (out_valid) begin
      phase    <= phase + 2'd1;
      idle_cnt <= '0;
    end else begin
      if (idle_cnt != GAP_LIM) begin
        idle_cnt <= idle_cnt + IW'(1);
      end
      if (idle_cnt == GAP_LIM - IW'(1)) begin
        phase <= 2'd0;
      end
    end
  end

  // Hold the first three bytes of the frame being assembled.
  always_ff @(posedge clk) begin
    if (out_valid) begin
      case (phase)
        2'd0:    byte0 <= out_data;
        2'd1:    byte1 <= out_data;
        2'd2:    byte2 <= out_data;
        default: ;
      endcase
    end
  end

  // Frame storage, packed as {R msb, R lsb, L msb, L lsb}.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {out_data, byte2, byte1, byte0};
    end
  end

  // Write pointer advance and dropped-frame accounting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr       <= '0;
      overflow_cnt <= 8'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (push_drop) begin
        overflow_cnt <= sat_inc8(overflow_cnt);
      end
    end
  end

  // Sample tick generator; the next period is chosen from the level at each tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
      period   <= PER_NOM;
    end else if (tick) begin
      tick_cnt <= '0;
      period   <= next_period;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // Playback FSM with registered sample outputs, strobe and underrun accounting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_FILL;
      playing      <= 1'b0;
      sample_stb   <= 1'b0;
      audio_lch    <= 16'h0000;
      audio_rch    <= 16'h0000;
      underrun_cnt <= 8'd0;
      rd_ptr       <= '0;
    end else begin
      sample_stb <= tick;
      if (pop) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
      if (tick) begin
        case (state)
          S_FILL: begin
            if (prefill_ok) begin
              state     <= S_PLAY;
              playing   <= 1'b1;
              audio_lch <= fmt_sample(rd_frame[7:0],   rd_frame[15:8]);
              audio_rch <= fmt_sample(rd_frame[23:16], rd_frame[31:24]);
            end else begin
              audio_lch <= MUTE;
              audio_rch <= MUTE;
            end
          end
          S_PLAY: begin
            if (level != '0) begin
              audio_lch <= fmt_sample(rd_frame[7:0],   rd_frame[15:8]);
              audio_rch <= fmt_sample(rd_frame[23:16], rd_frame[31:24]);
            end else begin
              audio_lch    <= MUTE;
              audio_rch    <= MUTE;
              underrun_cnt <= sat_inc8(underrun_cnt);
              state        <= S_FILL;
              playing      <= 1'b0;
            end
          end
          default: begin
            state   <= S_FILL;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_audio_playout_ctrl.sv
// Directed bench for usb_audio_playout_ctrl: a main instance with a short
// sample period and a second instance that never leaves prefill, used to
// fill the FIFO past capacity.
module tb_usb_audio_playout_ctrl;

  localparam int DIV = 400;

  typedef struct {
    logic [15:0] l_in;
    logic [15:0] r_in;
    logic [15:0] l_exp;
    logic [15:0] r_exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [15:0] audio_lch;
  logic [15:0] audio_rch;
  logic        sample_stb;
  logic        playing;
  logic [8:0]  fifo_level;
  logic [7:0]  underrun_cnt;
  logic [7:0]  overflow_cnt;

  logic [7:0]  ovf_data;
  logic        ovf_valid;
  logic [15:0] ovf_lch;
  logic [15:0] ovf_rch;
  logic        ovf_stb;
  logic        ovf_playing;
  logic [8:0]  ovf_level;
  logic [7:0]  ovf_underrun;
  logic [7:0]  ovf_overflow;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          ovf_stb_n = 0;

  int          stb_cyc;
  int          stb_lvl;
  logic [15:0] stb_l;
  logic [15:0] stb_r;
  logic        stb_play;

  usb_audio_playout_ctrl #(
    .CLK_DIV(DIV), .DEPTH_LOG2(8), .PREFILL(96), .HIGH_WM(192), .LOW_WM(48),
    .GAP_CYCLES(600), .UNSIGNED_OUT(1'b1)
  ) u_dut (
    .clk(clk), .rstn(rstn), .out_data(out_data), .out_valid(out_valid),
    .audio_lch(audio_lch), .audio_rch(audio_rch), .sample_stb(sample_stb),
    .playing(playing), .fifo_level(fifo_level), .underrun_cnt(underrun_cnt),
    .overflow_cnt(overflow_cnt)
  );

  usb_audio_playout_ctrl #(
    .CLK_DIV(DIV), .DEPTH_LOG2(8), .PREFILL(300), .HIGH_WM(192), .LOW_WM(48),
    .GAP_CYCLES(600), .UNSIGNED_OUT(1'b1)
  ) u_ovf (
    .clk(clk), .rstn(rstn), .out_data(ovf_data), .out_valid(ovf_valid),
    .audio_lch(ovf_lch), .audio_rch(ovf_rch), .sample_stb(ovf_stb),
    .playing(ovf_playing), .fifo_level(ovf_level), .underrun_cnt(ovf_underrun),
    .overflow_cnt(ovf_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (ovf_stb) ovf_stb_n <= ovf_stb_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_stb(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_stb) begin
        ok       = 1'b1;
        stb_cyc  = cyc;
        stb_lvl  = int'(fifo_level);
        stb_l    = audio_lch;
        stb_r    = audio_rch;
        stb_play = playing;
        break;
      end
    end
    check("stb_wait", ok, 1'b1);
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    out_data  = b;
    out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk); out_data = l[7:0];  out_valid = 1'b1;
    @(negedge clk); out_data = l[15:8];
    @(negedge clk); out_data = r[7:0];
    @(negedge clk); out_data = r[15:8];
    @(negedge clk); out_valid = 1'b0;
  endtask

  task automatic ovf_push_frame(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk); ovf_data = l[7:0];  ovf_valid = 1'b1;
    @(negedge clk); ovf_data = l[15:8];
    @(negedge clk); ovf_data = r[7:0];
    @(negedge clk); ovf_data = r[15:8];
    @(negedge clk); ovf_valid = 1'b0;
  endtask

  initial begin
    vec_t vecs [6];
    int   c0;
    int   lvl;
    int   prev_lvl;
    int   played;
    int   pc;
    bit   seen40;

    vecs[0] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    vecs[1] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    vecs[2] = '{16'h1234, 16'hABCD, 16'h9234, 16'h2BCD};
    vecs[3] = '{16'h00FF, 16'hFF00, 16'h80FF, 16'h7F00};
    vecs[4] = '{16'h5A5A, 16'hA5A5, 16'hDA5A, 16'h25A5};
    vecs[5] = '{16'h8001, 16'h7FFE, 16'h0001, 16'hFFFE};

    rstn      = 1'b0;
    out_data  = 8'h00;
    out_valid = 1'b0;
    ovf_data  = 8'h00;
    ovf_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lch", audio_lch, 16'h0000);
    check("rst_level", fifo_level, 9'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_playing", playing, 1'b0);
    check("rst_stb", sample_stb, 1'b0);
    check("rst_rch", audio_rch, 16'h0000);
    check("rst_cnts", {underrun_cnt, overflow_cnt}, 16'h0000);

    // Overflow: 260 frames with no pops
    for (int i = 0; i < 260; i++) ovf_push_frame(16'h1111, 16'h2222);
    check("ovf_level", ovf_level, 9'd256);
    check("ovf_overflow", ovf_overflow, 8'd4);
    check("ovf_playing", ovf_playing, 1'b0);
    check("ovf_underrun", ovf_underrun, 8'd0);
    check("ovf_mute_lch", ovf_lch, 16'h8000);
    check("ovf_stb_seen", ovf_stb_n > 0, 1'b1);
    check("fill_mute_lch", audio_lch, 16'h8000);
    check("fill_mute_rch", audio_rch, 16'h8000);

    // Prefill 96 frames at one byte per 10 clk, then first play
    for (int i = 0; i < 96; i++) begin
      put_byte(8'h34, 8);
      put_byte(8'h12, 8);
      put_byte(8'hCD, 8);
      put_byte(8'hAB, (i == 95) ? 0 : 8);
    end
    check("t1_level", fifo_level, 9'd96);
    check("t1_not_playing", playing, 1'b0);
    wait_stb(DIV + 100);
    check("t1_playing", stb_play, 1'b1);
    check("t1_lch", stb_l, 16'h9234);
    check("t1_rch", stb_r, 16'h2BCD);
    check("t1_level_after", stb_lvl, 95);
    c0 = stb_cyc;
    wait_stb(DIV + 100);
    check("t1_spacing", stb_cyc - c0, DIV);
    check("t1_lch2", stb_l, 16'h9234);

    // Drain to underrun; check the slow period when the tick sees level 40
    played   = 2;
    prev_lvl = stb_lvl;
    seen40   = 1'b0;
    for (int i = 0; i < 110; i++) begin
      pc = stb_cyc;
      wait_stb(DIV + 100);
      if (prev_lvl + 1 == 40) begin
        check("t6_spacing_lvl40", stb_cyc - pc, DIV + 1);
        seen40 = 1'b1;
      end
      if (stb_l == 16'h9234 && stb_play) played++;
      else break;
      prev_lvl = stb_lvl;
    end
    check("t2_played", played, 96);
    check("t2_mute_l", stb_l, 16'h8000);
    check("t2_mute_r", stb_r, 16'h8000);
    check("t2_playing", stb_play, 1'b0);
    check("t2_underrun", underrun_cnt, 8'd1);
    check("t6_seen", seen40, 1'b1);

    // Partial frame discarded by an idle gap
    put_byte(8'hAA, 8);
    put_byte(8'hBB, 8);
    put_byte(8'hCC, 0);
    repeat (700) @(negedge clk);
    put_byte(8'h01, 8);
    put_byte(8'h00, 8);
    put_byte(8'h02, 8);
    put_byte(8'h00, 0);
    check("t3_level", fifo_level, 9'd1);

    // Table frames behind it, padded to prefill
    for (int i = 0; i < 6; i++) push_frame(vecs[i].l_in, vecs[i].r_in);
    for (int i = 0; i < 89; i++) push_frame(16'h0101, 16'h0202);
    check("t3_prefill_level", fifo_level, 9'd96);
    wait_stb(DIV + 100);
    check("t3_playing", stb_play, 1'b1);
    check("t3_lch", stb_l, 16'h8001);
    check("t3_rch", stb_r, 16'h8002);
    for (int i = 0; i < 6; i++) begin
      wait_stb(DIV + 100);
      check($sformatf("vec%0d_lch", i), stb_l, vecs[i].l_exp);
      check($sformatf("vec%0d_rch", i), stb_r, vecs[i].r_exp);
    end

    // Push coinciding with pop at level 100
    wait_stb(DIV + 100);
    c0  = stb_cyc;
    lvl = stb_lvl;
    for (int i = 0; i < 100 - lvl; i++) push_frame(16'h0101, 16'h0202);
    @(negedge clk); out_data = 8'h11; out_valid = 1'b1;
    @(negedge clk); out_data = 8'h22;
    @(negedge clk); out_data = 8'h33;
    @(negedge clk); out_valid = 1'b0;
    while (cyc < c0 + DIV - 1) @(negedge clk);
    check("t7_level_before", fifo_level, 9'd100);
    out_data  = 8'h44;
    out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
    check("t7_level_after", fifo_level, 9'd100);
    check("t7_stb", sample_stb, 1'b1);
    check("t7_lch", audio_lch, 16'h8101);

    // High level shortens the period
    for (int i = 0; i < 106; i++) push_frame(16'h0101, 16'h0202);
    wait_stb(DIV + 100);
    c0 = stb_cyc;
    check("t5_level_high", stb_lvl > 192, 1'b1);
    wait_stb(DIV + 100);
    check("t5_spacing", stb_cyc - c0, DIV - 1);

    // Reset in the middle of a frame
    @(negedge clk); out_data = 8'h55; out_valid = 1'b1;
    @(negedge clk); out_data = 8'h66;
    @(negedge clk); out_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check("t8_lch", audio_lch, 16'h0000);
    check("t8_rch", audio_rch, 16'h0000);
    check("t8_level", fifo_level, 9'd0);
    check("t8_playing", playing, 1'b0);
    check("t8_cnts", {underrun_cnt, overflow_cnt, 7'd0, sample_stb}, 32'h0);
    check("t8_ovf_level", ovf_level, 9'd0);
    check("t8_ovf_overflow", ovf_overflow, 8'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); out_data = 8'h01; out_valid = 1'b1;
    @(negedge clk); out_data = 8'h02;
    @(negedge clk); out_data = 8'h03;
    @(negedge clk); out_valid = 1'b0;
    check("t8_partial_discarded", fifo_level, 9'd0);
    put_byte(8'h04, 0);
    check("t8_one_frame", fifo_level, 9'd1);
    wait_stb(DIV + 100);
    check("t8_fill_state", stb_play, 1'b0);
    check("t8_fill_mute", stb_l, 16'h8000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
